interrupt_sequencer: RTL
========================

Name: interrupt_sequencer

Overview:
- Interrupt controller that sequences the program counter's interrupt entry and return.
- Arbitrates prioritized IRQ lines and generates the vector address.
- Pulses the PC's interrupt and recovery enables.
- Keeps a LIFO of saved return addresses and priority levels so higher-priority interrupts can nest.
- Sits between peripheral IRQ sources and the instruction decoder on one side, and the program counter on the other.

Parameters:
- NUM_IRQ, 4, number of request lines; index 0 is highest priority.
- STACK_DEPTH, 4, maximum nesting depth (saved-PC entries).
- VECTOR_BASE, 16'hFF00, address of vector 0.
- VECTOR_STRIDE, 16'h0004, address distance between consecutive vectors.

Ports:
- clk  in  1  clock; all state on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- i_irq  in  NUM_IRQ  level-sensitive requests; held by the source until acked.
- i_irq_mask  in  NUM_IRQ  1 = line enabled.
- i_global_enable  in  1  master interrupt enable.
- i_reti  in  1  one-cycle pulse from the decoder on a return-from-interrupt instruction.
- i_pc_save  in  16  saved PC value presented by the PC on its save/recovery bus.
- o_interrupt_enable  out  1  one-cycle pulse; PC loads o_interrupt_address.
- o_interrupt_address  out  16  vector address; valid while o_interrupt_enable=1, else 0.
- o_recovery_enable  out  1  one-cycle pulse; PC restores from o_recovery_address.
- o_recovery_address  out  16  popped return address; valid while o_recovery_enable=1, else 0.
- o_irq_ack  out  NUM_IRQ  one-hot pulse in the ENTER cycle for the serviced line.
- o_active_id  out  $clog2(NUM_IRQ)  index of the interrupt currently in service.
- o_in_service  out  1  stack non-empty.
- o_stack_full  out  1  depth == STACK_DEPTH.
- o_error  out  1  sticky; set on i_reti with an empty stack. Cleared only by reset.

Behaviour:
- Reset: state IDLE, stack depth 0, all outputs 0, o_error 0. Reset mid-ENTER or mid-RETURN aborts; no partial push/pop survives.
- Pending vector: i_irq & i_irq_mask, gated by i_global_enable. Winner = lowest set index.
- Eligibility: winner exists, stack not full, and either the stack is empty or winner index < top-of-stack level (strictly higher priority). Equal or lower priority waits.
- States: IDLE, ENTER, SERVICE, RETURN.
- IDLE:
  - eligible winner at an edge -> ENTER.
  - i_reti -> stays IDLE, sets o_error.
- ENTER (exactly 1 cycle):
  - o_interrupt_enable=1, o_interrupt_address = VECTOR_BASE + winner*VECTOR_STRIDE (16-bit, wraps mod 2^16), o_irq_ack[winner]=1.
  - At the closing edge, push {i_pc_save, winner}; depth+1.
  - Winner is latched on entry to ENTER; request changes during ENTER are ignored.
  - Next state SERVICE.
- SERVICE:
  - i_reti -> RETURN. i_reti has priority over a simultaneous eligible IRQ.
  - Otherwise an eligible (higher-priority) winner -> ENTER (nesting).
- RETURN (exactly 1 cycle):
  - o_recovery_enable=1, o_recovery_address = top-of-stack PC.
  - Pop at the closing edge.
  - Next state: SERVICE if depth after pop > 0, else IDLE.
  - An i_reti arriving during RETURN is ignored.
- Back-to-back: after RETURN to IDLE, a still-pending request enters ENTER on the next edge. The minimum gap between o_recovery_enable and o_interrupt_enable is 1 cycle.
- o_interrupt_enable and o_recovery_enable are never high together.
- Stack full: no ENTER; requests remain pending. o_stack_full = (depth == STACK_DEPTH).
- o_active_id = top-of-stack level; 0 when the stack is empty.
- Latency: request asserted before edge N gives o_interrupt_enable during cycle N to N+1, and the PC is at the vector after edge N+1.
- All outputs are registered or decoded from registered state only. No combinational path from i_irq to outputs.

Test Plan:
- Reset then i_irq=4'b0100, mask=4'hF, enable=1 -> one ENTER cycle: o_interrupt_address=16'hFF08, o_irq_ack=4'b0100; i_pc_save=16'h0123 pushed; o_active_id=2, o_in_service=1.
- In service of IRQ2, assert i_irq[0] -> nested ENTER to 16'hFF00, depth 2. Assert i_irq[3] -> no entry. i_reti -> o_recovery_address = saved PC of the IRQ0 entry, active_id returns to 2.
- i_irq=4'b0011 simultaneously from IDLE -> IRQ0 serviced first. After its RETURN, IRQ1 enters exactly 1 cycle after o_recovery_enable.
- STACK_DEPTH=2: nest IRQ3, IRQ2, then raise IRQ1 -> o_stack_full=1, no ENTER until a RETURN. Then IRQ1 enters to 16'hFF04.
- i_reti in IDLE -> o_error=1 and sticky, no recovery pulse. i_reti and eligible IRQ in the same SERVICE cycle -> RETURN taken first.
- Assert n_rst low during ENTER -> all outputs 0, depth 0, state IDLE. The previously saved PC is not recoverable.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Prioritised interrupt sequencer: arbitrates IRQ lines, drives PC entry/return pulses
// and keeps a LIFO of {return PC, priority level} so higher-priority requests can nest.
module interrupt_sequencer #(
   parameter int          NUM_IRQ       = 4,
   parameter int          STACK_DEPTH   = 4,
   parameter logic [15:0] VECTOR_BASE   = 16'hFF00,
   parameter logic [15:0] VECTOR_STRIDE = 16'h0004,
   localparam int         ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [NUM_IRQ-1:0] i_irq_mask,
   input  logic               i_global_enable,
   input  logic               i_reti,
   input  logic [15:0]        i_pc_save,
   output logic               o_interrupt_enable,
   output logic [15:0]        o_interrupt_address,
   output logic               o_recovery_enable,
   output logic [15:0]        o_recovery_address,
   output logic [NUM_IRQ-1:0] o_irq_ack,
   output logic [ID_W-1:0]    o_active_id,
   output logic               o_in_service,
   output logic               o_stack_full,
   output logic               o_error,
   output logic [1:0]         o_dbg_state
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTER   = 2'd1,
      ST_SERVICE = 2'd2,
      ST_RETURN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic [ID_W-1:0]     winner_q, winner_d;
   logic                error_q, error_d;
   logic [15:0]         stack_pc_q  [STACK_DEPTH];
   logic [ID_W-1:0]     stack_lvl_q [STACK_DEPTH];

   logic [NUM_IRQ-1:0]  pending;
   logic                win_found;
   logic [ID_W-1:0]     win_idx;
   logic                eligible;
   logic                stack_empty;
   logic                stack_full;
   logic [PTR_W-1:0]    top_idx;
   logic [PTR_W-1:0]    push_idx;
   logic [ID_W-1:0]     top_lvl;

   assign stack_empty = (depth_q == '0);
   assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign top_idx     = PTR_W'(depth_q - DEPTH_W'(1));
   assign push_idx    = PTR_W'(depth_q);
   assign top_lvl     = stack_empty ? '0 : stack_lvl_q[top_idx];

   assign pending = i_irq & i_irq_mask & {NUM_IRQ{i_global_enable}};

   // Lowest set index wins; scanning downward lets the last hit be the winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(i);
         end
      end
   end

   assign eligible = win_found && !stack_full && (stack_empty || (win_idx < top_lvl));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (eligible) state_d = ST_ENTER;
         ST_ENTER:   state_d = ST_SERVICE;
         ST_SERVICE: begin
            if (i_reti)        state_d = ST_RETURN;
            else if (eligible) state_d = ST_ENTER;
         end
         ST_RETURN:  state_d = (depth_q > DEPTH_W'(1)) ? ST_SERVICE : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Entry and return are single-cycle pulses decoded from state; the PC acts on the
   // cycle the enable is high and needs no ready, so there is no back-pressure.
   always_comb begin
      o_interrupt_enable  = 1'b0;
      o_interrupt_address = '0;
      o_recovery_enable   = 1'b0;
      o_recovery_address  = '0;
      o_irq_ack           = '0;
      case (state_q)
         ST_ENTER: begin
            o_interrupt_enable  = 1'b1;
            o_interrupt_address = VECTOR_BASE + VECTOR_STRIDE * 16'(winner_q);
            o_irq_ack           = NUM_IRQ'(1) << winner_q;
         end
         ST_RETURN: begin
            o_recovery_enable   = 1'b1;
            o_recovery_address  = stack_pc_q[top_idx];
         end
         default: ;
      endcase
   end

   always_comb begin
      winner_d = winner_q;
      depth_d  = depth_q;
      error_d  = error_q;
      if (state_d == ST_ENTER && state_q != ST_ENTER) winner_d = win_idx;
      if (state_q == ST_ENTER)       depth_d = depth_q + DEPTH_W'(1);
      else if (state_q == ST_RETURN) depth_d = depth_q - DEPTH_W'(1);
      if (state_q == ST_IDLE && i_reti) error_d = 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         winner_q <= '0;
         depth_q  <= '0;
         error_q  <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_pc_q[i]  <= '0;
            stack_lvl_q[i] <= '0;
         end
      end else begin
         winner_q <= winner_d;
         depth_q  <= depth_d;
         error_q  <= error_d;
         if (state_q == ST_ENTER) begin
            stack_pc_q[push_idx]  <= i_pc_save;
            stack_lvl_q[push_idx] <= winner_q;
         end
      end
   end

   assign o_active_id  = top_lvl;
   assign o_in_service = !stack_empty;
   assign o_stack_full = stack_full;
   assign o_error      = error_q;
   assign o_dbg_state  = state_q;

endmodule
